music_seq_ctrl: RTL and testbench

//  Next-gen player sequencer between song select and the music ROM/address counter. Reads a
//  2-word tempo header, derives the note period with an iterative divider (no combinational

---
 rtl/music_seq_ctrl_pkg.sv | 29 ++
 rtl/music_seq_ctrl_if.sv | 35 +++
 rtl/music_seq_ctrl_div32.sv | 57 +++++
 rtl/music_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_music_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/music_seq_ctrl_pkg.sv
// Shared definitions for the music sequencer: song count, word width,
// end-of-song code, FSM state encoding and the tempo constant helper.
package music_seq_ctrl_pkg;

    localparam int         MSC_N_DEF    = 3;
    localparam int         DW_DEF       = 6;
    localparam logic [5:0] END_CODE_DEF = 6'b111000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        HDR_HI = 3'd2,
        HDR_LO = 3'd3,
        DIV    = 3'd4,
        PLAY   = 3'd5,
        FETCH  = 3'd6,
        HOLD   = 3'd7
    } msc_state_e;

    // Clock cycles per minute divided by notes per beat; the divider
    // turns this into cycles per note once bpm is known.
    function automatic logic [31:0] msc_k(input int unsigned clk_hz,
                                          input int unsigned subdiv);
        logic [63:0] k;
        k = (64'(clk_hz) * 64'd60) / 64'(subdiv);
        return k[31:0];
    endfunction

endpackage

// File: rtl/music_seq_ctrl_if.sv
// Bundle between song select / music ROM and the sequencer.
// There is no valid/ready pair here: sel, add, rom_clock, note_vld and
// play_end are single-cycle registered strobes that the receiver must take
// on the cycle they are high; start, pause and loop_en are levels, and
// rom_q is expected valid ROM_LAT cycles after a rom_clock strobe.
interface music_seq_ctrl_if
    import music_seq_ctrl_pkg::*;
#(
    parameter int MSC_N = MSC_N_DEF,
    parameter int DW    = DW_DEF
);
    logic [MSC_N-1:0] start;
    logic             pause;
    logic             loop_en;
    logic [DW-1:0]    rom_q;
    logic [MSC_N-1:0] sel;
    logic             add;
    logic             rom_clock;
    logic [DW-1:0]    note_out;
    logic             note_vld;
    logic             play_end;
    logic             busy;
    msc_state_e       state_dbg;

    modport master (
        output start, pause, loop_en, rom_q,
        input  sel, add, rom_clock, note_out, note_vld, play_end, busy, state_dbg
    );

    modport slave (
        input  start, pause, loop_en, rom_q,
        output sel, add, rom_clock, note_out, note_vld, play_end, busy, state_dbg
    );

endinterface

// File: rtl/music_seq_ctrl_div32.sv
// 32-step restoring divider. A start pulse loads the operands; one
// quotient bit is resolved per cycle. done is high during the cycle of
// the last step and quotient then carries the final result, so the
// caller can register it on the same edge the divider finishes.
module music_seq_ctrl_div32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic [4:0]  step_q;
    logic        run_q;

    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_nxt;

    // One shift-and-subtract step on the current partial remainder.
    always_comb begin
        rem_sh   = {rem_q, quo_q[31]};
        fits     = (rem_sh >= {1'b0, dsr_q});
        rem_nxt  = fits ? 32'(rem_sh - {1'b0, dsr_q}) : rem_sh[31:0];
        quotient = {quo_q[30:0], fits};
        done     = run_q && (step_q == 5'd31);
    end

    // Operand load on start, otherwise advance one step while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dsr_q  <= divisor;
            step_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q  <= rem_nxt;
            quo_q  <= quotient;
            step_q <= step_q + 5'd1;
            if (step_q == 5'd31) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/music_seq_ctrl.sv
// Player sequencer: reads a two-word tempo header, derives the note period
// with the iterative divider, then steps the ROM once per note period.
// Handles pause, looping at the end code and song change/stop at any time.
module music_seq_ctrl
    import music_seq_ctrl_pkg::*;
#(
    parameter int            MSC_N    = MSC_N_DEF,
    parameter int            DW       = DW_DEF,
    parameter int unsigned   CLK_HZ   = 50_000_000,
    parameter int unsigned   SUBDIV   = 4,
    parameter int            ROM_LAT  = 1,
    parameter logic [DW-1:0] END_CODE = DW'(END_CODE_DEF)
) (
    input logic             sysclk,
    input logic             rst_n,
    music_seq_ctrl_if.slave bus
);
    localparam logic [31:0] K   = msc_k(CLK_HZ, SUBDIV);
    localparam logic [1:0]  LAT = 2'(ROM_LAT);

    msc_state_e        state_q;
    logic [MSC_N-1:0]  start_d;
    logic [MSC_N-1:0]  song_q;
    logic [MSC_N-1:0]  sel_q;
    logic              add_q;
    logic              rom_clock_q;
    logic [DW-1:0]     note_q;
    logic              note_vld_q;
    logic              play_end_q;
    logic              busy_q;
    logic [2*DW-1:0]   bpm_q;
    logic [31:0]       period_q;
    logic [31:0]       cnt_q;
    logic [1:0]        lat_q;

    logic              begins;
    logic              ends;
    logic              lat_done;
    logic              cnt_last;
    logic [2*DW-1:0]   bpm_fix;
    logic              div_start;
    logic              div_done;
    logic [31:0]       div_q;

    // Start edge detect, ROM wait, note counter terminal and header fix-up.
    always_comb begin
        begins    = (bus.start != start_d) && (bus.start != '0);
        ends      = (bus.start != start_d) && (bus.start == '0);
        lat_done  = (lat_q == LAT);
        cnt_last  = (cnt_q == period_q - 32'd1);
        bpm_fix   = {bpm_q[2*DW-1:DW], bus.rom_q};
        if (bpm_fix == '0) begin
            bpm_fix = {{(2*DW-1){1'b0}}, 1'b1};
        end
        div_start = (state_q == HDR_LO) && lat_done && !ends && !begins;
    end

    music_seq_ctrl_div32 u_div (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (K),
        .divisor  (32'(bpm_fix)),
        .done     (div_done),
        .quotient (div_q)
    );

    // Sequencer FSM; stop beats song change beats pause beats normal flow.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_d     <= '0;
            song_q      <= '0;
            sel_q       <= '0;
            add_q       <= 1'b0;
            rom_clock_q <= 1'b0;
            note_q      <= '0;
            note_vld_q  <= 1'b0;
            play_end_q  <= 1'b0;
            busy_q      <= 1'b0;
            bpm_q       <= '0;
            period_q    <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
        end else begin
            start_d     <= bus.start;
            sel_q       <= '0;
            add_q       <= 1'b0;
            rom_clock_q <= 1'b0;
            note_vld_q  <= 1'b0;
            play_end_q  <= 1'b0;
            if (state_q != IDLE && ends) begin
                sel_q      <= MSC_N'(1);
                play_end_q <= 1'b1;
                note_q     <= '0;
                busy_q     <= 1'b0;
                state_q    <= IDLE;
            end else if (begins) begin
                song_q  <= bus.start;
                sel_q   <= bus.start;
                busy_q  <= 1'b1;
                state_q <= LOAD;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    LOAD: begin
                        rom_clock_q <= 1'b1;
                        add_q       <= 1'b1;
                        lat_q       <= '0;
                        state_q     <= HDR_HI;
                    end
                    HDR_HI: begin
                        if (lat_done) begin
                            bpm_q[2*DW-1:DW] <= bus.rom_q;
                            rom_clock_q      <= 1'b1;
                            add_q            <= 1'b1;
                            lat_q            <= '0;
                            state_q          <= HDR_LO;
                        end else begin
                            lat_q <= lat_q + 2'd1;
                        end
                    end
                    HDR_LO: begin
                        if (lat_done) begin
                            bpm_q   <= bpm_fix;
                            state_q <= DIV;
                        end else begin
                            lat_q <= lat_q + 2'd1;
                        end
                    end
                    DIV: begin
                        if (div_done) begin
                            period_q <= div_q;
                            cnt_q    <= '0;
                            state_q  <= PLAY;
                        end
                    end
                    // A HOLD cycle with pause released counts as a play cycle,
                    // so the note is late by exactly the paused cycles.
                    PLAY, HOLD: begin
                        if (bus.pause) begin
                            state_q <= HOLD;
                        end else if (cnt_last) begin
                            rom_clock_q <= 1'b1;
                            add_q       <= 1'b1;
                            lat_q       <= '0;
                            state_q     <= FETCH;
                        end else begin
                            cnt_q   <= cnt_q + 32'd1;
                            state_q <= PLAY;
                        end
                    end
                    FETCH: begin
                        if (!lat_done) begin
                            lat_q <= lat_q + 2'd1;
                        end else if (bus.rom_q != END_CODE) begin
                            note_q     <= bus.rom_q;
                            note_vld_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= PLAY;
                        end else if (bus.loop_en) begin
                            sel_q   <= song_q;
                            state_q <= LOAD;
                        end else begin
                            play_end_q <= 1'b1;
                            note_q     <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.add       = add_q;
    assign bus.rom_clock = rom_clock_q;
    assign bus.note_out  = note_q;
    assign bus.note_vld  = note_vld_q;
    assign bus.play_end  = play_end_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl with a small address-counter/ROM model.
// K = 1000*60/4 = 15000, ROM_LAT = 1, so a note takes period + 2 cycles.
module tb_music_seq_ctrl;
    import music_seq_ctrl_pkg::*;

    localparam int         N      = 3;
    localparam int         DW     = 6;
    localparam int         TMO    = 20000;
    localparam logic [5:0] NOTE_A = 6'h05;
    localparam logic [5:0] NOTE_B = 6'h0A;

    logic          sysclk = 1'b0;
    logic          rst_n  = 1'b0;
    int            tests  = 0;
    int            fails  = 0;
    int            cyc    = 0;
    int            pe_cnt = 0;
    int            sel_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [5:0]    mem [0:47];
    logic [5:0]    rom_addr;

    music_seq_ctrl_if #(.MSC_N(N), .DW(DW)) bus ();

    music_seq_ctrl #(
        .MSC_N   (N),
        .DW      (DW),
        .CLK_HZ  (1000),
        .SUBDIV  (4),
        .ROM_LAT (1)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Clock and cycle counter.
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [5:0] base_of(input logic [2:0] s);
        if (s[0]) return 6'd0;
        else if (s[1]) return 6'd16;
        else return 6'd32;
    endfunction

    // Address counter and 1-cycle-latency ROM.
    always @(posedge sysclk) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            bus.rom_q  <= '0;
        end else begin
            if (bus.sel != '0) rom_addr <= base_of(bus.sel);
            else if (bus.add) rom_addr <= rom_addr + 6'd1;
            if (bus.rom_clock) bus.rom_q <= mem[rom_addr];
        end
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge sysclk) begin
        if (bus.play_end === 1'b1) pe_cnt++;
        if (bus.sel != '0) sel_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input msc_state_e s, output int at);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.state_dbg !== s && n < TMO);
        at = cyc;
        check(tag, bus.state_dbg, s);
    endtask

    task automatic wait_note(input string tag, output int at);
        int n = 0;
        logic [DW-1:0] e;
        do begin
            tick(1);
            n++;
        end while (bus.note_vld !== 1'b1 && n < TMO);
        at = cyc;
        check({tag, "_vld"}, bus.note_vld, 1);
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check({tag, "_val"}, bus.note_out, e);
    endtask

    initial begin
        int c_div, c_play, c_a, c_b, c_a2, c_b2, c_n1, c_n2, c_f, pe0, sel0;
        for (int i = 0; i < 48; i++) mem[i] = '0;
        mem[0]  = 6'h01;  mem[1]  = 6'h38;  mem[2]  = NOTE_A; mem[3] = NOTE_B; mem[4] = 6'h38;
        mem[16] = 6'h00;  mem[17] = 6'h3C;  mem[18] = 6'h11;  mem[19] = 6'h12; mem[20] = 6'h38;
        mem[32] = 6'h00;  mem[33] = 6'h00;  mem[34] = 6'h21;  mem[35] = 6'h38;
        bus.start   = '0;
        bus.pause   = 1'b0;
        bus.loop_en = 1'b0;

        // Reset values
        rst_n = 1'b0;
        tick(3);
        check("rst_sel",       bus.sel, 0);
        check("rst_strobes",   {bus.add, bus.rom_clock, bus.note_vld, bus.play_end}, 0);
        check("rst_note",      bus.note_out, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_state",     bus.state_dbg, IDLE);
        rst_n = 1'b1;
        tick(2);
        check("idle_after_rst", bus.state_dbg, IDLE);

        // 1: bpm 120 -> period 125, notes 127 apart
        bus.start = 3'b001;
        tick(1);
        check("t1_sel",  bus.sel, 3'b001);
        check("t1_load", bus.state_dbg, LOAD);
        check("t1_busy", bus.busy, 1);
        tick(1);
        check("t1_hdr_strobe", {bus.rom_clock, bus.add}, 2'b11);
        check("t1_hdr_hi",     bus.state_dbg, HDR_HI);
        wait_state("t1_div", DIV, c_div);
        wait_state("t1_play", PLAY, c_play);
        check("t1_div_len", c_play - c_div, 32);
        exp_q.push_back(NOTE_A);
        exp_q.push_back(NOTE_B);
        wait_note("t1_note_a", c_a);
        check("t1_first_gap", c_a - c_play, 127);
        wait_note("t1_note_b", c_b);
        check("t1_spacing", c_b - c_a, 127);

        // 2: END with loop off -> one play_end, idle, note cleared
        pe0 = pe_cnt;
        wait_state("t2_idle", IDLE, c_f);
        check("t2_end_gap",  c_f - c_b, 127);
        check("t2_play_end", bus.play_end, 1);
        check("t2_busy",     bus.busy, 0);
        check("t2_note_clr", bus.note_out, 0);
        tick(2);
        check("t2_pe_count", pe_cnt - pe0, 1);

        // Stop request while idle is ignored
        bus.start = '0;
        tick(3);
        check("t3_stop_in_idle", pe_cnt - pe0, 1);
        check("t3_idle_state",   bus.state_dbg, IDLE);

        // 3: loop on -> header re-read, A replays, no play_end
        bus.loop_en = 1'b1;
        sel0 = sel_cnt;
        pe0  = pe_cnt;
        bus.start = 3'b001;
        exp_q.push_back(NOTE_A);
        exp_q.push_back(NOTE_B);
        exp_q.push_back(NOTE_A);
        wait_note("t3_a", c_a);
        wait_note("t3_b", c_b);
        wait_note("t3_a_again", c_a2);
        check("t3_loop_gap",    c_a2 - c_b, 291);
        check("t3_sel_pulses",  sel_cnt - sel0, 2);
        check("t3_no_play_end", pe_cnt - pe0, 0);

        // 4: pause 40 cycles mid-PLAY delays next note by 40
        exp_q.push_back(NOTE_B);
        tick(20);
        bus.pause = 1'b1;
        tick(1);
        check("t4_hold", bus.state_dbg, HOLD);
        tick(39);
        check("t4_held_note",  bus.note_out, NOTE_A);
        check("t4_still_hold", bus.state_dbg, HOLD);
        bus.pause = 1'b0;
        wait_note("t4_b", c_b2);
        check("t4_delay", c_b2 - c_a2, 167);

        // Stop from PLAY
        pe0 = pe_cnt;
        bus.start = '0;
        tick(1);
        check("t5_stop_sel",  bus.sel, 3'b001);
        check("t5_stop_pe",   bus.play_end, 1);
        check("t5_stop_idle", bus.state_dbg, IDLE);
        check("t5_stop_note", bus.note_out, 0);
        check("t5_stop_busy", bus.busy, 0);
        bus.loop_en = 1'b0;

        // 5: song change during DIV, new header bpm 60 -> period 250
        bus.start = 3'b001;
        wait_state("t5_div", DIV, c_div);
        tick(5);
        bus.start = 3'b010;
        tick(1);
        check("t5_new_sel",  bus.sel, 3'b010);
        check("t5_new_load", bus.state_dbg, LOAD);
        exp_q.push_back(6'h11);
        exp_q.push_back(6'h12);
        wait_state("t5_play", PLAY, c_play);
        wait_note("t5_n1", c_n1);
        check("t5_first_gap", c_n1 - c_play, 252);
        wait_note("t5_n2", c_n2);
        check("t5_spacing", c_n2 - c_n1, 252);
        bus.start = '0;
        tick(1);
        check("t5_end_sel", bus.sel, 3'b001);
        check("t5_end_pe",  bus.play_end, 1);
        tick(2);
        check("t5_pe_count", pe_cnt - pe0, 2);

        // 6: zero header -> bpm 1, period 15000; reset mid-FETCH
        bus.start = 3'b100;
        wait_state("t6_play", PLAY, c_play);
        wait_state("t6_fetch", FETCH, c_f);
        check("t6_period",    c_f - c_play, 15000);
        check("t6_rom_clock", bus.rom_clock, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_strobes", {bus.sel, bus.add, bus.rom_clock, bus.note_vld, bus.play_end}, 0);
        check("t6_rst_busy",    bus.busy, 0);
        check("t6_rst_state",   bus.state_dbg, IDLE);
        bus.start = '0;
        pe0 = pe_cnt;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("t6_no_pulse",  pe_cnt - pe0, 0);
        check("t6_idle_busy", bus.busy, 0);
        check("sb_drained",   exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
